// File: rtl/sumador_pkg.sv
// rtl/sumador_pkg.sv - shared key codes, FSM states and display field encodings
package sumador_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    ADD_REQ,
    ADD_WAIT,
    SHOW
  } state_t;

  localparam logic [1:0] FIELD_A   = 2'd0;
  localparam logic [1:0] FIELD_B   = 2'd1;
  localparam logic [1:0] FIELD_SUM = 2'd2;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/acumulador_decimal.sv
// rtl/acumulador_decimal.sv - one decimal operand register with digit counter
// Priority clear > load > shift; value_next lets the top register the display in step.
module acumulador_decimal #(
  parameter int N_DIGITS = 3,
  parameter int OP_W     = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            shift,
  input  logic [3:0]      digit,
  output logic [OP_W-1:0] value,
  output logic [OP_W-1:0] value_next
);

  localparam int CW = $clog2(N_DIGITS + 1);

  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [OP_W+3:0] times10;

  always_comb begin
    times10    = ({4'b0, value} << 3) + ({4'b0, value} << 1);
    value_next = value;
    count_d    = count_q;
    if (clear) begin
      value_next = '0;
      count_d    = '0;
    end else if (load) begin
      value_next = OP_W'(digit);
      count_d    = CW'(1);
    end else if (shift && (count_q < CW'(N_DIGITS))) begin
      // Parameter constraint guarantees the truncation never drops a set bit.
      value_next = OP_W'(times10) + OP_W'(digit);
      count_d    = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value   <= '0;
      count_q <= '0;
    end else begin
      value   <= value_next;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/control_sumador.sv
// rtl/control_sumador.sv - keypad-to-adder sequencer: operand entry, add handshake, result hold
module control_sumador
  import sumador_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int OP_W     = 10,
  parameter int TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  input  logic [3:0]      key_code,
  output logic [OP_W-1:0] add_a,
  output logic [OP_W-1:0] add_b,
  output logic            add_start,
  input  logic            add_done,
  input  logic [OP_W:0]   add_sum,
  output logic [OP_W:0]   disp_value,
  output logic [1:0]      disp_field,
  output logic            result_valid,
  output logic            busy,
  output logic            err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [OP_W:0]   sum_q, sum_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            valid_d, err_d;
  logic [OP_W:0]   disp_d;
  logic [1:0]      field_d;
  logic            a_clr, a_load, a_shift, b_clr, b_shift;
  logic [OP_W-1:0] a_next, b_next;
  logic            key_digit, key_add, key_eq, key_clr;

  assign key_digit = key_valid && is_digit(key_code);
  assign key_add   = key_valid && (key_code == KEY_ADD);
  assign key_eq    = key_valid && (key_code == KEY_EQ);
  assign key_clr   = key_valid && (key_code == KEY_CLR);

  acumulador_decimal #(.N_DIGITS(N_DIGITS), .OP_W(OP_W)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .clear      (a_clr),
    .load       (a_load),
    .shift      (a_shift),
    .digit      (key_code),
    .value      (add_a),
    .value_next (a_next)
  );

  acumulador_decimal #(.N_DIGITS(N_DIGITS), .OP_W(OP_W)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .clear      (b_clr),
    .load       (1'b0),
    .shift      (b_shift),
    .digit      (key_code),
    .value      (add_b),
    .value_next (b_next)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    timer_d = timer_q;
    valid_d = result_valid;
    err_d   = err;
    a_clr   = 1'b0;
    a_load  = 1'b0;
    a_shift = 1'b0;
    b_clr   = 1'b0;
    b_shift = 1'b0;

    // CLEAR is common to every key-accepting state; ADD_REQ/ADD_WAIT ignore all keys.
    if (key_clr && (state_q == ENTER_A || state_q == ENTER_B || state_q == SHOW)) begin
      a_clr   = 1'b1;
      b_clr   = 1'b1;
      sum_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      state_d = ENTER_A;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (key_digit) begin
            a_shift = 1'b1;
          end else if (key_add) begin
            b_clr   = 1'b1;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_digit) begin
            b_shift = 1'b1;
          end else if (key_eq) begin
            state_d = ADD_REQ;
          end
        end
        ADD_REQ: begin
          timer_d = '0;
          state_d = ADD_WAIT;
        end
        ADD_WAIT: begin
          if (add_done) begin
            sum_d   = add_sum;
            valid_d = 1'b1;
            state_d = SHOW;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            sum_d   = '0;
            err_d   = 1'b1;
            state_d = SHOW;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        SHOW: begin
          if (key_digit) begin
            a_load  = 1'b1;
            b_clr   = 1'b1;
            valid_d = 1'b0;
            err_d   = 1'b0;
            state_d = ENTER_A;
          end
        end
        default: state_d = ENTER_A;
      endcase
    end

    disp_d  = '0;
    field_d = FIELD_A;
    case (state_d)
      ENTER_A: begin
        disp_d  = {1'b0, a_next};
        field_d = FIELD_A;
      end
      ENTER_B, ADD_REQ, ADD_WAIT: begin
        disp_d  = {1'b0, b_next};
        field_d = FIELD_B;
      end
      default: begin
        disp_d  = sum_d;
        field_d = FIELD_SUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ENTER_A;
      sum_q        <= '0;
      timer_q      <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      add_start    <= 1'b0;
      busy         <= 1'b0;
      disp_value   <= '0;
      disp_field   <= FIELD_A;
    end else begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      timer_q      <= timer_d;
      result_valid <= valid_d;
      err          <= err_d;
      add_start    <= (state_d == ADD_REQ);
      busy         <= (state_d == ADD_REQ) || (state_d == ADD_WAIT);
      disp_value   <= disp_d;
      disp_field   <= field_d;
    end
  end

endmodule

// File: doc/control_sumador.md
# control_sumador

Sequencer between the keypad scanner and the adder datapath. Consumes one-cycle key events (decoded 4-bit key codes), builds two unsigned decimal operands digit by digit, launches one addition on the external adder through a start/done handshake with timeout, and holds the result for the display driver. It owns all operator-entry state; the scanner and adder stay stateless with respect to the calculation.

## Interface
- N_DIGITS, 3: maximum decimal digits per operand.
- OP_W, 10: operand width; must satisfy 2^OP_W > 10^N_DIGITS − 1.
- TIMEOUT, 255: cycles to wait for add_done before aborting.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- key_valid  in  1  one-cycle pulse, key_code valid.
- key_code  in  4  0–9 digit, 4'hA ADD, 4'hB EQUALS, 4'hC CLEAR, others ignored.
- add_a  out  OP_W  operand A to adder.
- add_b  out  OP_W  operand B to adder.
- add_start  out  1  one-cycle request to adder.
- add_done  in  1  one-cycle completion from adder.
- add_sum  in  OP_W+1  adder result, valid with add_done.
- disp_value  out  OP_W+1  value the display shows.
- disp_field  out  2  0 = A, 1 = B, 2 = result.
- result_valid  out  1  high while a good result is displayed.
- busy  out  1  high in ADD_REQ/ADD_WAIT.
- err  out  1  high while a timed-out result is displayed.

## Operation
- States: ENTER_A, ENTER_B, ADD_REQ, ADD_WAIT, SHOW.
- ENTER_A: digit d, digit count < N_DIGITS → A ← A·10 + d, count++. Digit at count = N_DIGITS → ignored. ADD → ENTER_B, count ← 0, B ← 0. EQUALS → ignored.
- ENTER_B: digits as for A, into B. EQUALS → ADD_REQ (zero digits entered means B = 0). ADD → ignored.
- ADD_REQ: add_start = 1 for exactly this one cycle; → ADD_WAIT, timer ← 0.
- ADD_WAIT: add_done → latch add_sum, result_valid ← 1, → SHOW. Timer reaching TIMEOUT with no add_done → sum ← 0, err ← 1, → SHOW. Every key, including CLEAR, ignored.
- SHOW: digit d → A ← d, count ← 1, B ← 0, result_valid/err ← 0, → ENTER_A. CLEAR → ENTER_A with all cleared. ADD/EQUALS ignored.
- CLEAR in ENTER_A/ENTER_B/SHOW: A, B, sum, count ← 0, flags ← 0, → ENTER_A.
- Multiply-by-10 is computed as (x<<3)+(x<<1) at OP_W+4 bits and truncated to OP_W; no overflow is possible given the parameter constraint.
- disp_value/disp_field: ENTER_A → A/0; ENTER_B, ADD_REQ, ADD_WAIT → B/1; SHOW → sum/2. A and B are zero-extended to OP_W+1.

## Timing
- Reset: state ENTER_A; A, B, sum, count, timer 0; add_start, busy, result_valid, err 0; disp_value 0; disp_field 0.
- All outputs registered. A key accepted on edge n is reflected in the operand and disp_value after edge n.
- EQUALS in ENTER_B at edge n: add_start high for cycle n+1 only; busy high from n+1 until the SHOW transition.
- add_a/add_b stable from ADD_REQ through the end of ADD_WAIT.
- add_done is sampled only in ADD_WAIT; add_done outside ADD_WAIT is ignored. add_done on the same edge the timer hits TIMEOUT: add_done wins, err = 0.
- Minimum add_done latency is 1 cycle after add_start.
- Asynchronous reset mid-operation (including ADD_WAIT) returns to reset values immediately. A late add_done after reset is ignored.

## Structure
- Package sumador_pkg: key-code constants (KEY_ADD = 4'hA, KEY_EQ = 4'hB, KEY_CLR = 4'hC), state enum type, disp_field encodings.
- Sub-module acumulador_decimal: one operand register plus digit counter, with load/clear/shift-in-digit controls and the N_DIGITS limit. Instantiated twice, for A and B.
- Timeout counter and FSM live in the top module.

## Test plan
- Keys 1,2,3,ADD,4,5,EQUALS; adder responds 2 cycles after start with 168 → one add_start pulse, add_a = 123, add_b = 45, disp_value = 168, disp_field = 2, result_valid = 1.
- Keys 9,9,9,9 → A = 999; fourth digit ignored; disp_value = 999.
- Keys 7,ADD,EQUALS → add_b = 0, add_start pulses; add_done with 7 → SHOW, sum = 7.
- add_done never asserted → exactly TIMEOUT+1 cycles after add_start: err = 1, disp_value = 0, result_valid = 0; then key 5 → ENTER_A, A = 5, err = 0.
- CLEAR in ENTER_B with A = 12, B = 3 → all zero, disp_field = 0; CLEAR and digits during ADD_WAIT ignored.
- rst asserted mid-ADD_WAIT, then add_done pulsed → all outputs at reset values, no transition to SHOW.
